tri_raster_scanner: RTL
=======================

// Module: tri_raster_scanner
// PURPOSE
// - Initiator side of the point-in-triangle query: takes one triangle, scans its screen-clamped bounding box in raster order.
// - Issues one point query per pixel to the in-triangle test unit, waits for its verdict and emits every covered pixel as a fragment.
// - Sits between triangle setup (upstream) and the framebuffer writer (downstream); one query outstanding at a time.
// PARAMETERS
// - SYS_BIT_WIDTH  32   coordinate width; matches the query unit
// - H_RES          320  screen width; valid x range is 0..H_RES-1
// - V_RES          180  screen height; valid y range is 0..V_RES-1
// PORTS
// - clk_in               in   1    system clock
// - rst_in               in   1    asynchronous, active-high reset
// - tri_valid_in         in   1    triangle present on tri_* inputs
// - tri_ax/ay/bx/by/cx/cy_in  in  SYS_BIT_WIDTH each  vertex A/B/C coordinates (unsigned)
// - ready_out            out  1    high only in IDLE; triangle accepted when tri_valid_in & ready_out
// - query_valid_out      out  1    one-cycle pulse that starts a query
// - query_ax..query_cy   out  SYS_BIT_WIDTH x6  latched vertices; stable for the whole job
// - query_px/py_out      out  SYS_BIT_WIDTH  pixel under test; stable from ISSUE until its result
// - result_valid_in      in   1    verdict strobe from the query unit
// - result_inside_in     in   1    verdict; 1 = inside or on an edge
// - pixel_valid_out      out  1    one-cycle fragment strobe
// - pixel_x/y_out        out  SYS_BIT_WIDTH  fragment coordinates
// - done_out             out  1    one-cycle pulse when the job finishes
// BEHAVIOUR
// - Reset (async, any state): state=IDLE.
//   - ready_out=1; query_valid_out, pixel_valid_out and done_out are 0; all coordinate outputs are 0.
// - IDLE: on accept, latch the six vertices and go to BBOX. tri_valid_in is ignored in every other state.
// - BBOX (1 cycle):
//   - min_x = min(ax,bx,cx) and max_x = min(max(ax,bx,cx), H_RES-1); same for y with V_RES.
//   - If min_x > H_RES-1 or min_y > V_RES-1 (fully off-screen), go to DONE.
//   - Otherwise set x=min_x, y=min_y and go to ISSUE.
// - ISSUE (1 cycle): query_valid_out=1 with query_px/py=(x,y); go to WAIT.
// - WAIT: hold until result_valid_in; the query unit's latency is variable.
//   - If result_inside_in, pulse pixel_valid_out on the next cycle with pixel_x/y=(x,y). The pixel_x/y outputs hold their value between strobes.
//   - Advance: if x<max_x then x++. Else x=min_x; if y==max_y go to DONE, else y++. Otherwise go to ISSUE.
//   - Last pixel: its fragment pulse (if any) comes in the same cycle as the move to DONE. done_out is one cycle later, so it is never before the last fragment.
// - result_valid_in outside WAIT is ignored, including a stray verdict after reset.
// - DONE (1 cycle): done_out=1, then go to IDLE.
// - Arithmetic: compares and increments are unsigned in SYS_BIT_WIDTH. x/y never go past max, so there is no wrap-around.
// - A degenerate triangle (all vertices equal, or collinear) is still scanned over its bounding box.
// CONFIGURATION
// - SCAN_STATS_EN defined: adds two outputs.
//   - tested_count_out [31:0]: +1 per result taken in WAIT.
//   - inside_count_out [31:0]: +1 per fragment.
//   - Both clear on triangle accept, saturate at 2^32-1, hold after done_out, and reset to 0.
// - SCAN_STATS_EN undefined: these ports and counters do not exist.
// TESTING
// Responder model: exact edge-inclusive math; answers 3 cycles after query_valid_out; screen 8x8 unless stated.
// - A(2,2) B(4,2) C(2,4):
//   - 9 queries (2,2),(3,2),(4,2),(2,3)..(4,4) in that order.
//   - 6 fragments: (2,2),(3,2),(4,2),(2,3),(3,3),(2,4).
//   - done_out one cycle after the last fragment strobe; stats 9/6.
// - A(10,1) B(12,1) C(11,3): no query_valid_out, done_out 3 cycles after accept, ready_out back high.
// - A(6,0) B(20,0) C(6,2): no query with x>7 or y>2.
// - A=B=C=(5,5): exactly one query (5,5), one fragment (5,5).
// - rst_in pulsed after the 4th query: all outputs 0, ready_out=1; the late result_valid_in is ignored; the next triangle starts at its own min corner.
// - tri_valid_in held high through a job: the 2nd triangle is accepted only the cycle after done_out.

Source files
------------

// File: rtl/tri_raster_scanner_if.sv
// rtl/tri_raster_scanner_if.sv - handshake bundle between the raster scanner and its neighbours
// Purpose: groups the triangle input, query/result exchange, fragment output
//          and job-done strobe of tri_raster_scanner into one interface.
// Modports:
//   slave  - the scanner: takes tri_* and result_*, drives ready, query_*,
//            pixel_*, done (and the stats counters when SCAN_STATS_EN is defined)
//   master - the surrounding logic: the mirror image of slave
// Signals:
//   tri_valid_in, tri_{ax,ay,bx,by,cx,cy}_in   triangle offered by setup
//   ready_out                                  scanner idle, triangle taken on valid&ready
//   query_valid_out, query_{ax..cy}_out,
//   query_px_out, query_py_out                 point query to the in-triangle unit
//   result_valid_in, result_inside_in          verdict from the in-triangle unit
//   pixel_valid_out, pixel_x_out, pixel_y_out  covered-pixel fragment
//   done_out                                   job finished
//   tested_count_out, inside_count_out         SCAN_STATS_EN only
interface tri_raster_scanner_if #(
    parameter int SYS_BIT_WIDTH = 32
);
    logic                     tri_valid_in;
    logic [SYS_BIT_WIDTH-1:0] tri_ax_in;
    logic [SYS_BIT_WIDTH-1:0] tri_ay_in;
    logic [SYS_BIT_WIDTH-1:0] tri_bx_in;
    logic [SYS_BIT_WIDTH-1:0] tri_by_in;
    logic [SYS_BIT_WIDTH-1:0] tri_cx_in;
    logic [SYS_BIT_WIDTH-1:0] tri_cy_in;
    logic                     ready_out;
    logic                     query_valid_out;
    logic [SYS_BIT_WIDTH-1:0] query_ax_out;
    logic [SYS_BIT_WIDTH-1:0] query_ay_out;
    logic [SYS_BIT_WIDTH-1:0] query_bx_out;
    logic [SYS_BIT_WIDTH-1:0] query_by_out;
    logic [SYS_BIT_WIDTH-1:0] query_cx_out;
    logic [SYS_BIT_WIDTH-1:0] query_cy_out;
    logic [SYS_BIT_WIDTH-1:0] query_px_out;
    logic [SYS_BIT_WIDTH-1:0] query_py_out;
    logic                     result_valid_in;
    logic                     result_inside_in;
    logic                     pixel_valid_out;
    logic [SYS_BIT_WIDTH-1:0] pixel_x_out;
    logic [SYS_BIT_WIDTH-1:0] pixel_y_out;
    logic                     done_out;
`ifdef SCAN_STATS_EN
    logic [31:0]              tested_count_out;
    logic [31:0]              inside_count_out;
`endif

    modport slave (
        input  tri_valid_in, tri_ax_in, tri_ay_in, tri_bx_in, tri_by_in, tri_cx_in, tri_cy_in,
        input  result_valid_in, result_inside_in,
        output ready_out, query_valid_out,
        output query_ax_out, query_ay_out, query_bx_out, query_by_out, query_cx_out, query_cy_out,
        output query_px_out, query_py_out,
        output pixel_valid_out, pixel_x_out, pixel_y_out, done_out
`ifdef SCAN_STATS_EN
        , output tested_count_out, inside_count_out
`endif
    );

    modport master (
        output tri_valid_in, tri_ax_in, tri_ay_in, tri_bx_in, tri_by_in, tri_cx_in, tri_cy_in,
        output result_valid_in, result_inside_in,
        input  ready_out, query_valid_out,
        input  query_ax_out, query_ay_out, query_bx_out, query_by_out, query_cx_out, query_cy_out,
        input  query_px_out, query_py_out,
        input  pixel_valid_out, pixel_x_out, pixel_y_out, done_out
`ifdef SCAN_STATS_EN
        , input tested_count_out, inside_count_out
`endif
    );
endinterface

// File: rtl/tri_raster_scanner.sv
// rtl/tri_raster_scanner.sv - raster scan of a triangle's screen-clamped bounding box
// Purpose: accepts one triangle, walks its bounding box (clamped to the screen)
//          in raster order, issues one point query per pixel with a single
//          query outstanding, and emits each covered pixel as a fragment.
// Ports:
//   clk_in  - system clock
//   rst_in  - asynchronous active-high reset
//   bus     - tri_raster_scanner_if.slave (triangle in, query/result, fragments, done)
// Optional feature: SCAN_STATS_EN adds tested_count_out / inside_count_out.
module tri_raster_scanner #(
    parameter int SYS_BIT_WIDTH = 32,
    parameter int H_RES         = 320,
    parameter int V_RES         = 180
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    tri_raster_scanner_if.slave  bus
);
    localparam int W = SYS_BIT_WIDTH;
    localparam logic [W-1:0] X_LAST = W'(H_RES - 1);
    localparam logic [W-1:0] Y_LAST = W'(V_RES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BBOX  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]   state;
    logic [W-1:0] ax, ay, bx, by, cx, cy;
    logic [W-1:0] min_x, max_x, min_y, max_y;
    logic [W-1:0] x, y;
    logic [W-1:0] pix_x, pix_y;
    logic         pix_valid;
    logic         done_q;
    logic         ready;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    logic [W-1:0] bb_min_x, bb_min_y, bb_max_x_raw, bb_max_y_raw;
    assign bb_min_x     = min3(ax, bx, cx);
    assign bb_min_y     = min3(ay, by, cy);
    assign bb_max_x_raw = max3(ax, bx, cx);
    assign bb_max_y_raw = max3(ay, by, cy);

    // done_out is registered off the DONE state so that it trails the last
    // fragment by one cycle; ready stays low during that strobe so a held
    // tri_valid_in is only taken the cycle after done_out.
    assign ready = (state == S_IDLE) && !done_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            ax        <= '0;
            ay        <= '0;
            bx        <= '0;
            by        <= '0;
            cx        <= '0;
            cy        <= '0;
            min_x     <= '0;
            max_x     <= '0;
            min_y     <= '0;
            max_y     <= '0;
            x         <= '0;
            y         <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            done_q    <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.tri_valid_in && ready) begin
                        ax    <= bus.tri_ax_in;
                        ay    <= bus.tri_ay_in;
                        bx    <= bus.tri_bx_in;
                        by    <= bus.tri_by_in;
                        cx    <= bus.tri_cx_in;
                        cy    <= bus.tri_cy_in;
                        state <= S_BBOX;
                    end
                end
                S_BBOX: begin
                    min_x <= bb_min_x;
                    min_y <= bb_min_y;
                    max_x <= (bb_max_x_raw > X_LAST) ? X_LAST : bb_max_x_raw;
                    max_y <= (bb_max_y_raw > Y_LAST) ? Y_LAST : bb_max_y_raw;
                    if (bb_min_x > X_LAST || bb_min_y > Y_LAST) begin
                        state <= S_DONE;
                    end else begin
                        x     <= bb_min_x;
                        y     <= bb_min_y;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.result_valid_in) begin
                        if (bus.result_inside_in) begin
                            pix_valid <= 1'b1;
                            pix_x     <= x;
                            pix_y     <= y;
                        end
                        if (x < max_x) begin
                            x     <= x + 1'b1;
                            state <= S_ISSUE;
                        end else begin
                            x <= min_x;
                            if (y == max_y) begin
                                state <= S_DONE;
                            end else begin
                                y     <= y + 1'b1;
                                state <= S_ISSUE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_STATS_EN
    logic [31:0] tested_cnt, inside_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tested_cnt <= '0;
            inside_cnt <= '0;
        end else if (state == S_IDLE && bus.tri_valid_in && ready) begin
            tested_cnt <= '0;
            inside_cnt <= '0;
        end else if (state == S_WAIT && bus.result_valid_in) begin
            if (tested_cnt != 32'hFFFF_FFFF) begin
                tested_cnt <= tested_cnt + 32'd1;
            end
            if (bus.result_inside_in && inside_cnt != 32'hFFFF_FFFF) begin
                inside_cnt <= inside_cnt + 32'd1;
            end
        end
    end

    assign bus.tested_count_out = tested_cnt;
    assign bus.inside_count_out = inside_cnt;
`endif

    assign bus.ready_out       = ready;
    assign bus.query_valid_out = (state == S_ISSUE);
    assign bus.query_ax_out    = ax;
    assign bus.query_ay_out    = ay;
    assign bus.query_bx_out    = bx;
    assign bus.query_by_out    = by;
    assign bus.query_cx_out    = cx;
    assign bus.query_cy_out    = cy;
    assign bus.query_px_out    = x;
    assign bus.query_py_out    = y;
    assign bus.pixel_valid_out = pix_valid;
    assign bus.pixel_x_out     = pix_x;
    assign bus.pixel_y_out     = pix_y;
    assign bus.done_out        = done_q;
endmodule
